// File: rtl/keccak_obi_arbiter.sv
// Round-robin arbiter sharing one OBI master port between NumReq requesters.
// Issued requester IDs are queued in order so each rvalid is steered back to its issuer.
package keccak_obi_pkg;
  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module keccak_obi_arbiter_lane
  import keccak_obi_pkg::*;
#(
  parameter int unsigned     IdxW = 2,
  parameter logic [IdxW-1:0] Idx  = '0
) (
  input  logic            hs_i,
  input  logic [IdxW-1:0] gnt_idx_i,
  input  logic            pop_i,
  input  logic [IdxW-1:0] rsp_idx_i,
  input  logic [31:0]     rdata_i,
  output obi_resp_t       resp_o
);
  assign resp_o.gnt    = hs_i && (gnt_idx_i == Idx);
  assign resp_o.rvalid = pop_i && (rsp_idx_i == Idx);
  assign resp_o.rdata  = rdata_i;
endmodule

module keccak_obi_arbiter
  import keccak_obi_pkg::*;
#(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  obi_req_t  [NumReq-1:0] slaves_req_i,
  output obi_resp_t [NumReq-1:0] slaves_resp_o,
  output obi_req_t               master_req_o,
  input  obi_resp_t              master_resp_i,
  output logic                   busy_o,
  output logic                   err_o
);
  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic {ARB, HOLD} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic [IdxW-1:0] sel_q, sel_d;
  logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [IdxW-1:0] fifo_q [MaxOutstanding];

  logic            cand_vld;
  logic [IdxW-1:0] cand;
  logic [IdxW-1:0] scan;
  logic            full, empty, issue, hs, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : PtrW'(p + 1'b1);
  endfunction

  // Candidate: locked owner in HOLD, otherwise first requester at or after rr_q.
  always_comb begin
    cand_vld = 1'b0;
    cand     = sel_q;
    scan     = '0;
    if (state_q == HOLD) begin
      cand_vld = slaves_req_i[sel_q].req;
    end else begin
      for (int k = 0; k < NumReq; k++) begin
        scan = IdxW'((32'(rr_q) + 32'(k)) % NumReq);
        if (!cand_vld && slaves_req_i[scan].req) begin
          cand_vld = 1'b1;
          cand     = scan;
        end
      end
    end
  end

  assign full  = (cnt_q == CntW'(MaxOutstanding));
  assign empty = (cnt_q == '0);
  // Gating with rst_i keeps every output quiet during the reset cycles themselves.
  assign issue = cand_vld && !full && !rst_i;
  assign hs    = issue && master_resp_i.gnt;
  assign pop   = master_resp_i.rvalid && !empty && !rst_i;

  always_comb begin
    master_req_o = '0;
    if (issue) begin
      master_req_o     = slaves_req_i[cand];
      master_req_o.req = 1'b1;
    end
  end

  for (genvar g = 0; g < NumReq; g++) begin : g_lane
    keccak_obi_arbiter_lane #(
      .IdxW (IdxW),
      .Idx  (IdxW'(g))
    ) u_lane (
      .hs_i      (hs),
      .gnt_idx_i (cand),
      .pop_i     (pop),
      .rsp_idx_i (fifo_q[rd_q]),
      .rdata_i   (master_resp_i.rdata),
      .resp_o    (slaves_resp_o[g])
    );
  end

  assign busy_o = !rst_i && (!empty || issue);
  assign err_o  = err_q && !rst_i;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    case (state_q)
      ARB: begin
        if (issue && !master_resp_i.gnt) begin
          state_d = HOLD;
          sel_d   = cand;
        end
      end
      HOLD: begin
        // A withdrawn request releases the lock rather than wedging the port.
        if (hs || !cand_vld) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
    if (hs) rr_d = (cand == IdxW'(NumReq - 1)) ? '0 : IdxW'(cand + 1'b1);
  end

  always_comb begin
    wr_d  = hs  ? ptr_inc(wr_q) : wr_q;
    rd_d  = pop ? ptr_inc(rd_q) : rd_q;
    cnt_d = cnt_q;
    if (hs && !pop)      cnt_d = CntW'(cnt_q + 1'b1);
    else if (!hs && pop) cnt_d = CntW'(cnt_q - 1'b1);
    err_d = err_q || (master_resp_i.rvalid && empty);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB;
      rr_q    <= '0;
      sel_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (hs) fifo_q[wr_q] <= cand;
  end
endmodule
